// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver: FSM states, legal
// configuration minimums and the mid-bit sampling offsets.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP_2,
        BREAK
    } rx_state_t;

    localparam int MIN_DATA_LEN = 5;
    localparam int MIN_PRESCALE = 8;
    localparam int SAMPLE_EARLY = 1;
    localparam int SAMPLE_LATE  = 1;

    // Out-of-range lengths are pulled back into the supported window.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
        if (int'(len) < MIN_DATA_LEN) return 4'(MIN_DATA_LEN);
        if (int'(len) > max_len) return 4'(max_len);
        return len;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the UART receiver: edge/bit counters and a 3-sample majority vote
// taken around the middle of each bit period.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  rx,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [3:0]            bit_cnt,
    output logic                  tick,
    output logic                  bit_val
);

    localparam logic [PRESCALE_W-1:0] ONE   = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] EARLY = PRESCALE_W'(SAMPLE_EARLY);
    localparam logic [PRESCALE_W-1:0] LATE  = PRESCALE_W'(SAMPLE_LATE);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] mid;
    logic [2:0]            samples;

    assign mid = prescale >> 1;

    // Counters sit at zero whenever the FSM is outside a frame, so each start edge restarts them.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            samples  <= '0;
            tick     <= 1'b0;
        end else begin
            if (edge_cnt == prescale - ONE) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + ONE;
            end
            if (edge_cnt == mid - EARLY) samples[0] <= rx;
            if (edge_cnt == mid)         samples[1] <= rx;
            if (edge_cnt == mid + LATE)  samples[2] <= rx;
            tick <= (edge_cnt == mid + LATE);
        end
    end

    assign bit_val = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                     (samples[1] & samples[2]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_BREAK_DET_EN to add line-break detection and the break_det port.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int MAX_DATA_WIDTH = 9,
    parameter int PRESCALE_W     = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_W-1:0]     Prescale,
    input  logic [3:0]                DATA_LEN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    output logic [MAX_DATA_WIDTH-1:0] P_DATA,
    output logic                      par_err,
    output logic                      frm_err,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic                      overrun
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic                      break_det
`endif
);

    logic                      sync1;
    logic                      sync2;
    logic                      rx_prev;
    logic                      fall;
    rx_state_t                 state;
    rx_state_t                 state_next;
    logic [PRESCALE_W-1:0]     prescale_q;
    logic [3:0]                len_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic                      stop2_q;
    logic [MAX_DATA_WIDTH-1:0] data_q;
    logic                      par_acc;
    logic                      frm_acc;
    logic                      run;
    logic                      start_det;
    logic                      shift_en;
    logic                      par_chk;
    logic                      stop1_chk;
    logic                      frame_done;
    logic                      tick;
    logic                      bit_val;
    logic [3:0]                bit_cnt;
`ifdef UART_RX_BREAK_DET_EN
    logic                      par_bit_q;
    logic                      brk;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= RX_IN;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    assign fall = rx_prev & ~sync2;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk      (CLK),
        .rst      (RST),
        .run      (run),
        .rx       (sync2),
        .prescale (prescale_q),
        .bit_cnt  (bit_cnt),
        .tick     (tick),
        .bit_val  (bit_val)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Every state advances on the mid-bit decision, so the final stop completes the frame early.
    always_comb begin
        state_next = state;
        run        = 1'b1;
        start_det  = 1'b0;
        shift_en   = 1'b0;
        par_chk    = 1'b0;
        stop1_chk  = 1'b0;
        frame_done = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk        = 1'b0;
`endif
        case (state)
            IDLE: begin
                run = 1'b0;
                if (fall) begin
                    state_next = START;
                    start_det  = 1'b1;
                end
            end
            START: if (tick) state_next = bit_val ? IDLE : DATA;
            DATA: if (tick) begin
                shift_en = 1'b1;
                if (bit_cnt == len_q) state_next = par_en_q ? PARITY : STOP;
            end
            PARITY: if (tick) begin
                par_chk    = 1'b1;
                state_next = STOP;
            end
            STOP: if (tick) begin
                stop1_chk = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                if (!bit_val && data_q == '0 && !(par_en_q && par_bit_q)) begin
                    state_next = BREAK;
                    brk        = 1'b1;
                end else
`endif
                if (stop2_q) begin
                    state_next = STOP_2;
                end else begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                end
            end
            STOP_2: if (tick) begin
                state_next = IDLE;
                frame_done = 1'b1;
            end
            BREAK: begin
                run = 1'b0;
                if (sync2) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Configuration is frozen at the start edge so mid-frame input changes cannot corrupt it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prescale_q <= '0;
            len_q      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            data_q     <= '0;
            par_acc    <= 1'b0;
            frm_acc    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_q  <= 1'b0;
`endif
        end else begin
            if (start_det) begin
                prescale_q <= (Prescale < PRESCALE_W'(MIN_PRESCALE)) ?
                              PRESCALE_W'(MIN_PRESCALE) : Prescale;
                len_q      <= clamp_len(DATA_LEN, MAX_DATA_WIDTH);
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                stop2_q    <= STOP2;
                data_q     <= '0;
                par_acc    <= 1'b0;
                frm_acc    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                par_bit_q  <= 1'b0;
`endif
            end
            if (shift_en) begin
                for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
                    if (4'(i) == bit_cnt - 4'd1) data_q[i] <= bit_val;
                end
            end
            if (par_chk) begin
                par_acc <= (bit_val != (^data_q ^ par_typ_q));
`ifdef UART_RX_BREAK_DET_EN
                par_bit_q <= bit_val;
`endif
            end
            if (stop1_chk) frm_acc <= ~bit_val;
        end
    end

    // A completing frame replaces the held one only if it is empty or being drained this cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            P_DATA     <= '0;
            par_err    <= 1'b0;
            frm_err    <= 1'b0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (data_valid && data_ready) data_valid <= 1'b0;
            if (frame_done) begin
                if (!data_valid || data_ready) begin
                    P_DATA     <= data_q;
                    par_err    <= par_acc;
                    frm_err    <= frm_acc | ~bit_val;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always_ff @(posedge CLK) begin
        if (RST) break_det <= 1'b0;
        else     break_det <= brk;
    end
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus randomized frames compared
// against a frame-level reference model; break checks follow UART_RX_BREAK_DET_EN.
module tb_uart_rx_cfg;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic [3:0] DATA_LEN = 4'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       STOP2 = 1'b0;
    logic       data_ready = 1'b1;
    logic [8:0] P_DATA;
    logic       par_err;
    logic       frm_err;
    logic       data_valid;
    logic       overrun;
`ifdef UART_RX_BREAK_DET_EN
    logic       break_det;
`endif

    typedef struct packed {
        logic [8:0] data;
        logic       par;
        logic       frm;
    } frame_t;

    frame_t obs_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     ovr_cnt = 0;
    int     brk_cnt = 0;
    int     valid_cycles = 0;
    int     rise_cyc = 0;
    int     last_start = 0;
    logic   dv_prev = 1'b0;

    uart_rx_cfg dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .DATA_LEN   (DATA_LEN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .P_DATA     (P_DATA),
        .par_err    (par_err),
        .frm_err    (frm_err),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun)
`ifdef UART_RX_BREAK_DET_EN
        ,
        .break_det  (break_det)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Observes handshakes and pulses on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if (!RST) begin
            if (data_valid && data_ready) obs_q.push_back({P_DATA, par_err, frm_err});
            if (overrun) ovr_cnt++;
            if (data_valid && !dv_prev) rise_cyc = cyc;
            if (data_valid) valid_cycles++;
`ifdef UART_RX_BREAK_DET_EN
            if (break_det) brk_cnt++;
`endif
            dv_prev = data_valid;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_bit(input logic v, input int n);
        RX_IN = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input int p, input int len, input bit pen, input bit ptyp,
                              input bit s2, input logic [8:0] data, input bit pbit,
                              input bit st1, input bit st2);
        Prescale = 6'(p);
        DATA_LEN = 4'(len);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        STOP2    = s2;
        @(posedge CLK);
        #1;
        last_start = cyc;
        drive_bit(1'b0, p);
        for (int i = 0; i < len; i++) drive_bit(data[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(st1, p);
        if (s2) drive_bit(st2, p);
        drive_bit(1'b1, 4);
    endtask

    task automatic wait_obs(input int budget, output bit got);
        for (int i = 0; i < budget && obs_q.size() == 0; i++) @(posedge CLK);
        #1;
        got = (obs_q.size() != 0);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++; if (P_DATA !== 9'h000) begin n_err++; $display("[TB] FAIL reset_p_data: got %h expected 000", P_DATA); end
        n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b expected 0", data_valid); end
        n_cmp++; if (par_err !== 1'b0) begin n_err++; $display("[TB] FAIL reset_par: got %b expected 0", par_err); end
        n_cmp++; if (frm_err !== 1'b0) begin n_err++; $display("[TB] FAIL reset_frm: got %b expected 0", frm_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ovr: got %b expected 0", overrun); end
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
    endtask

    task automatic test_8n1();
        frame_t f;
        bit     got;
        int     v0;
        v0 = valid_cycles;
        send_frame(8, 8, 0, 0, 0, 9'h0A5, 0, 1, 1);
        wait_obs(20, got);
        n_cmp++; if (!got) begin n_err++; $display("[TB] FAIL 8n1_delivered: got none expected 1 frame"); end
        else begin
            f = obs_q.pop_front();
            n_cmp++; if (f.data !== 9'h0A5) begin n_err++; $display("[TB] FAIL 8n1_data: got %h expected 0a5", f.data); end
            n_cmp++; if (f.par !== 1'b0 || f.frm !== 1'b0) begin n_err++; $display("[TB] FAIL 8n1_flags: got par=%b frm=%b expected 0 0", f.par, f.frm); end
        end
        n_cmp++; if (valid_cycles - v0 !== 1) begin n_err++; $display("[TB] FAIL 8n1_valid_width: got %0d cycles expected 1", valid_cycles - v0); end
    endtask

    task automatic test_7e2();
        frame_t f;
        bit     got;
        send_frame(16, 7, 1, 0, 1, 9'h055, 1, 1, 1);
        wait_obs(20, got);
        n_cmp++; if (!got) begin n_err++; $display("[TB] FAIL 7e2_par_delivered: got none expected 1 frame"); end
        else begin
            f = obs_q.pop_front();
            n_cmp++; if (f.data !== 9'h055 || f.par !== 1'b1 || f.frm !== 1'b0) begin n_err++; $display("[TB] FAIL 7e2_par_frame: got %h par=%b frm=%b expected 055 par=1 frm=0", f.data, f.par, f.frm); end
        end
        send_frame(16, 7, 1, 0, 1, 9'h055, 0, 1, 0);
        wait_obs(20, got);
        n_cmp++; if (!got) begin n_err++; $display("[TB] FAIL 7e2_stop_delivered: got none expected 1 frame"); end
        else begin
            f = obs_q.pop_front();
            n_cmp++; if (f.data !== 9'h055 || f.par !== 1'b0 || f.frm !== 1'b1) begin n_err++; $display("[TB] FAIL 7e2_stop_frame: got %h par=%b frm=%b expected 055 par=0 frm=1", f.data, f.par, f.frm); end
        end
    endtask

    task automatic test_widths();
        frame_t f;
        bit     got;
        send_frame(32, 9, 1, 1, 0, 9'h1FF, 0, 1, 1);
        wait_obs(20, got);
        n_cmp++; if (!got) begin n_err++; $display("[TB] FAIL 9o1_delivered: got none expected 1 frame"); end
        else begin
            f = obs_q.pop_front();
            n_cmp++; if (f.data !== 9'h1FF || f.par !== 1'b0 || f.frm !== 1'b0) begin n_err++; $display("[TB] FAIL 9o1_frame: got %h par=%b frm=%b expected 1ff par=0 frm=0", f.data, f.par, f.frm); end
        end
        send_frame(8, 5, 0, 0, 0, 9'h1FF, 0, 1, 1);
        wait_obs(20, got);
        n_cmp++; if (!got) begin n_err++; $display("[TB] FAIL 5n1_delivered: got none expected 1 frame"); end
        else begin
            f = obs_q.pop_front();
            n_cmp++; if (f.data !== 9'h01F) begin n_err++; $display("[TB] FAIL 5n1_data: got %h expected 01f", f.data); end
        end
    endtask

    task automatic test_glitch();
        frame_t f;
        bit     got;
        Prescale = 6'd16;
        DATA_LEN = 4'd8;
        PAR_EN   = 1'b0;
        STOP2    = 1'b0;
        @(posedge CLK);
        #1;
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 48);
        n_cmp++; if (obs_q.size() != 0 || data_valid !== 1'b0) begin n_err++; $display("[TB] FAIL glitch_ignored: got %0d frames valid=%b expected 0 0", obs_q.size(), data_valid); end
        send_frame(16, 8, 0, 0, 0, 9'h03C, 0, 1, 1);
        wait_obs(20, got);
        n_cmp++; if (!got) begin n_err++; $display("[TB] FAIL glitch_next_delivered: got none expected 1 frame"); end
        else begin
            f = obs_q.pop_front();
            n_cmp++; if (f.data !== 9'h03C) begin n_err++; $display("[TB] FAIL glitch_next_data: got %h expected 03c", f.data); end
        end
    endtask

    task automatic test_mid_reset();
        frame_t f;
        bit     got;
        Prescale = 6'd8;
        DATA_LEN = 4'd8;
        @(posedge CLK);
        #1;
        drive_bit(1'b0, 32);
        RST   = 1'b1;
        RX_IN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        drive_bit(1'b1, 100);
        n_cmp++; if (obs_q.size() != 0 || data_valid !== 1'b0 || P_DATA !== 9'h000) begin n_err++; $display("[TB] FAIL midreset_discard: got %0d frames valid=%b data=%h expected 0 0 000", obs_q.size(), data_valid, P_DATA); end
        send_frame(8, 8, 0, 0, 0, 9'h096, 0, 1, 1);
        wait_obs(20, got);
        n_cmp++; if (!got) begin n_err++; $display("[TB] FAIL midreset_next: got none expected 1 frame"); end
        else begin
            f = obs_q.pop_front();
            n_cmp++; if (f.data !== 9'h096) begin n_err++; $display("[TB] FAIL midreset_data: got %h expected 096", f.data); end
        end
    endtask

    task automatic test_back_to_back();
        frame_t f;
        bit     got;
        int     o0;
        int     lat;
        o0 = ovr_cnt;
        data_ready = 1'b0;
        send_frame(8, 8, 0, 0, 0, 9'h011, 0, 1, 1);
        send_frame(8, 8, 0, 0, 0, 9'h022, 0, 1, 1);
        n_cmp++; if (ovr_cnt - o0 !== 1) begin n_err++; $display("[TB] FAIL overrun_count: got %0d expected 1", ovr_cnt - o0); end
        n_cmp++; if (P_DATA !== 9'h011 || data_valid !== 1'b1) begin n_err++; $display("[TB] FAIL overrun_held: got %h valid=%b expected 011 1", P_DATA, data_valid); end
        data_ready = 1'b1;
        @(posedge CLK);
        #1;
        n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("[TB] FAIL drain_valid: got %b expected 0", data_valid); end
        wait_obs(4, got);
        n_cmp++; if (!got) begin n_err++; $display("[TB] FAIL drain_delivered: got none expected 011"); end
        else begin
            f = obs_q.pop_front();
            n_cmp++; if (f.data !== 9'h011) begin n_err++; $display("[TB] FAIL drain_data: got %h expected 011", f.data); end
        end
        // measure completion latency, then assert ready only in the completion cycle
        send_frame(8, 8, 0, 0, 0, 9'h05A, 0, 1, 1);
        lat = rise_cyc - last_start;
        wait_obs(4, got);
        if (got) f = obs_q.pop_front();
        data_ready = 1'b0;
        send_frame(8, 8, 0, 0, 0, 9'h033, 0, 1, 1);
        o0 = ovr_cnt;
        fork
            send_frame(8, 8, 0, 0, 0, 9'h044, 0, 1, 1);
            begin
                @(posedge CLK);
                #1;
                repeat (lat - 1) @(posedge CLK);
                #1;
                data_ready = 1'b1;
                @(posedge CLK);
                #1;
                data_ready = 1'b0;
            end
        join
        n_cmp++; if (ovr_cnt !== o0) begin n_err++; $display("[TB] FAIL coincide_overrun: got %0d pulses expected 0", ovr_cnt - o0); end
        n_cmp++; if (P_DATA !== 9'h044 || data_valid !== 1'b1) begin n_err++; $display("[TB] FAIL coincide_load: got %h valid=%b expected 044 1", P_DATA, data_valid); end
        n_cmp++; if (obs_q.size() != 1 || obs_q[0].data !== 9'h033) begin n_err++; $display("[TB] FAIL coincide_handoff: got %0d frames expected 1 frame 033", obs_q.size()); end
        obs_q.delete();
        data_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        obs_q.delete();
    endtask

    task automatic test_break();
        frame_t f;
        bit     got;
        int     b0;
        b0 = brk_cnt;
        Prescale = 6'd8;
        DATA_LEN = 4'd8;
        PAR_EN   = 1'b0;
        STOP2    = 1'b0;
        @(posedge CLK);
        #1;
        drive_bit(1'b0, 160);
        drive_bit(1'b1, 20);
`ifdef UART_RX_BREAK_DET_EN
        n_cmp++; if (brk_cnt - b0 !== 1) begin n_err++; $display("[TB] FAIL break_pulse: got %0d expected 1", brk_cnt - b0); end
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("[TB] FAIL break_no_data: got %0d frames expected 0", obs_q.size()); end
        obs_q.delete();
`else
        wait_obs(4, got);
        n_cmp++; if (!got) begin n_err++; $display("[TB] FAIL break_delivered: got none expected 1 frame"); end
        else begin
            f = obs_q.pop_front();
            n_cmp++; if (f.data !== 9'h000 || f.frm !== 1'b1 || f.par !== 1'b0) begin n_err++; $display("[TB] FAIL break_frame: got %h par=%b frm=%b expected 000 par=0 frm=1", f.data, f.par, f.frm); end
        end
`endif
        send_frame(8, 8, 0, 0, 0, 9'h0C3, 0, 1, 1);
        wait_obs(20, got);
        n_cmp++; if (!got) begin n_err++; $display("[TB] FAIL break_recover: got none expected 0c3 (brk %0d)", brk_cnt - b0); end
        else begin
            f = obs_q.pop_front();
            n_cmp++; if (f.data !== 9'h0C3) begin n_err++; $display("[TB] FAIL break_recover_data: got %h expected 0c3", f.data); end
        end
    endtask

    task automatic test_random();
        frame_t     f;
        bit         got;
        int         p;
        int         len;
        int         b0;
        bit         pen, ptyp, s2, pbit, st1, st2;
        bit         exp_par, exp_frm, is_brk;
        logic [8:0] data, mask, exp_data;
        for (int n = 0; n < 24; n++) begin
            p    = $urandom_range(8, 20);
            len  = $urandom_range(5, 9);
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            s2   = 1'($urandom_range(0, 1));
            pbit = 1'($urandom_range(0, 1));
            st1  = ($urandom_range(0, 3) != 0);
            st2  = ($urandom_range(0, 3) != 0);
            data = 9'($urandom);
            if ($urandom_range(0, 5) == 0) data = '0;
            mask     = 9'((1 << len) - 1);
            exp_data = data & mask;
            exp_par  = pen && (pbit != (^exp_data ^ ptyp));
            exp_frm  = !st1 || (s2 && !st2);
            is_brk   = (exp_data == 0) && (!pen || !pbit) && !st1;
            b0 = brk_cnt;
            send_frame(p, len, pen, ptyp, s2, data, pbit, st1, st2);
`ifdef UART_RX_BREAK_DET_EN
            if (is_brk) begin
                n_cmp++; if (brk_cnt - b0 !== 1 || obs_q.size() != 0) begin n_err++; $display("[TB] FAIL rand%0d_break: got pulses=%0d frames=%0d expected 1 0", n, brk_cnt - b0, obs_q.size()); end
                obs_q.delete();
                continue;
            end
`endif
            wait_obs(20, got);
            n_cmp++; if (!got) begin n_err++; $display("[TB] FAIL rand%0d_delivered: got none expected %h (brk %b)", n, exp_data, is_brk); end
            else begin
                f = obs_q.pop_front();
                n_cmp++; if (f.data !== exp_data || f.par !== exp_par || f.frm !== exp_frm) begin n_err++; $display("[TB] FAIL rand%0d_frame: got %h par=%b frm=%b expected %h par=%b frm=%b (P=%0d len=%0d)", n, f.data, f.par, f.frm, exp_data, exp_par, exp_frm, p, len); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e2();
        test_widths();
        test_glitch();
        test_mid_reset();
        test_back_to_back();
        test_break();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
